issue_queue: RTL and testbench
==============================

// Module: issue_queue
// PURPOSE
//  Buffered, parametrised issue stage between ID and ROB/RS/LSB. Queues decoded instructions in a FIFO,
//  dispatches the head in order when the ROB and the target unit (RS or LSB) have room, and resolves
//  operands against the register-status file, the CDB and its own last dispatch. Adds back-pressure,
//  flush and operand forwarding to the combinational issue path.
// PARAMETERS
//  DEPTH  4   FIFO entries (power of 2, >=2)
//  XLEN   32  data/pc/imm width
//  OP_W   6   opcode width (def.v encoding)
//  TAG_W  4   ROB tag width; tag {TAG_W{1'b1}} = TAG_READY (operand value valid)
// PORTS
//  clk_in       in   1      clock
//  rst_in       in   1      async reset, active-high
//  rdy_in       in   1      global stall-release; low = freeze
//  clear        in   1      misprediction flush
//  in_valid     in   1      ID has an instruction
//  in_ready     out  1      queue accepts (count<DEPTH)
//  in_op/in_rd/in_rs1/in_rs2  in  OP_W/5/5/5  decoded fields
//  in_imm/in_pc in   XLEN   immediate, pc
//  rf_rs1/rf_rs2 out 5      head source regs (combinational)
//  rf_q1/rf_q2  in   TAG_W  regfile status (TAG_READY = value valid)
//  rf_v1/rf_v2  in   XLEN   regfile values
//  rob_full, rs_full, lsb_full  in  1  consumer has no free slot
//  rob_tag      in   TAG_W  ROB's next free tag
//  cdb_valid/cdb_tag/cdb_data   in  1/TAG_W/XLEN  result broadcast
//  rob_we, rs_we, lsb_we, rf_we  out 1  registered one-cycle write strobes
//  d_op/d_pc/d_imm/d_rd   out  OP_W/XLEN/XLEN/5  dispatched fields (shared by all consumers)
//  d_q1/d_v1/d_q2/d_v2    out  TAG_W/XLEN        resolved operands
//  d_tag        out  TAG_W  ROB tag of dispatched instr (also rf_we rename tag)
// BEHAVIOUR
//  Reset: FIFO empty, all *_we 0, all data outputs 0, bypass invalid; in_ready 1.
//  Enqueue: in_valid&&in_ready&&rdy_in&&!clear pushes at tail. Entry is visible at head next cycle (min latency ID->dispatch strobe = 2).
//  Dispatch condition (cycle N): head valid && rdy_in && !clear && !rob_full && !(is_mem ? lsb_full : rs_full).
//    Pops head; at N+1 rob_we=1 and rs_we xor lsb_we =1 for exactly one cycle; outputs hold until next dispatch.
//  Routing: lb/lh/lw/lbu/lhu/sb/sh/sw -> LSB; all others -> RS. rf_we=1 unless store, branch, or rd==0.
//  Operand sources: rs1 for R/I/branch/jalr/load/store; rs2 for R/branch/store. Unused: q=TAG_READY with
//    v = imm (I-type, load, jalr), pc (jal/auipc src1), 4 (jal src2), 0 (lui src1); store imm on d_imm.
//  Resolution priority per source: reg x0 -> READY/0; last dispatch renamed this reg (bypass: prev rf_we &&
//    prev rd==rs, registered) -> prev tag, then CDB check on that tag; else rf_q; if q!=READY && cdb_valid &&
//    cdb_tag==q -> READY/cdb_data.
//  Consumers must snoop CDB in the cycle they sample *_we; forwarding at N+1 is theirs.
//  Full: in_ready=0 at count==DEPTH even if dispatching (no same-cycle pass-through). Empty: no strobes.
//  Pointers wrap mod DEPTH; count width clog2(DEPTH)+1. Simultaneous push+pop keeps count.
//  clear: FIFO emptied, bypass invalidated, all *_we 0 next cycle; in_valid that cycle dropped.
//  rdy_in low: FIFO/pointers/bypass frozen, *_we registers forced 0, data outputs held.
//  Async reset mid-dispatch: strobes drop immediately, no partial write.
// STRUCTURE
//  def.v: opcode constants, TAG_READY, is_mem/is_store/is_branch classification macros.
//  Sub-module issue_fifo (DEPTH, entry width) holds queue/pointers/count; resolver + dispatch regs in top.
// TESTING
//  1 addi x1,x0,5 with rf ready, all unit free -> 2 cycles later rob_we=rs_we=rf_we=1, d_q1=READY d_v1=0, d_v2=5.
//  2 add x2,x1,x1 right after addi x1 (tag 3) -> d_q1=d_q2=3 via bypass; same with cdb_tag=3,data=9 at dispatch -> READY/9.
//  3 sw x1,8(x2) with lsb_full=1 for 3 cycles -> no strobe, queue holds; on release lsb_we=1, rf_we=0, d_imm=8.
//  4 push DEPTH+1 instrs with rob_full=1 -> in_ready=0 after DEPTH; release -> in-order dispatch, one per cycle, pointers wrap.
//  5 clear with 3 entries queued and dispatch pending -> no strobe next cycle, in_ready=1, next push dispatches normally.
//  6 add x0,x1,x2 -> rf_we=0; rdy_in low 2 cycles mid-stream -> no strobes, order preserved after.

Source files
------------

// File: rtl/issue_queue_pkg.sv
// Opcode encoding, operand-source classes and decode helpers shared by
// the issue queue and anything that needs to agree with its encoding.
package issue_queue_pkg;

  localparam int OPC_W = 6;
  typedef logic [OPC_W-1:0] opc_t;

  localparam opc_t OP_NOP   = 6'd0;
  localparam opc_t OP_LUI   = 6'd1;
  localparam opc_t OP_AUIPC = 6'd2;
  localparam opc_t OP_JAL   = 6'd3;
  localparam opc_t OP_JALR  = 6'd4;
  localparam opc_t OP_BEQ   = 6'd5;
  localparam opc_t OP_BNE   = 6'd6;
  localparam opc_t OP_BLT   = 6'd7;
  localparam opc_t OP_BGE   = 6'd8;
  localparam opc_t OP_BLTU  = 6'd9;
  localparam opc_t OP_BGEU  = 6'd10;
  localparam opc_t OP_LB    = 6'd11;
  localparam opc_t OP_LH    = 6'd12;
  localparam opc_t OP_LW    = 6'd13;
  localparam opc_t OP_LBU   = 6'd14;
  localparam opc_t OP_LHU   = 6'd15;
  localparam opc_t OP_SB    = 6'd16;
  localparam opc_t OP_SH    = 6'd17;
  localparam opc_t OP_SW    = 6'd18;
  localparam opc_t OP_ADDI  = 6'd19;
  localparam opc_t OP_SLTI  = 6'd20;
  localparam opc_t OP_SLTIU = 6'd21;
  localparam opc_t OP_XORI  = 6'd22;
  localparam opc_t OP_ORI   = 6'd23;
  localparam opc_t OP_ANDI  = 6'd24;
  localparam opc_t OP_SLLI  = 6'd25;
  localparam opc_t OP_SRLI  = 6'd26;
  localparam opc_t OP_SRAI  = 6'd27;
  localparam opc_t OP_ADD   = 6'd28;
  localparam opc_t OP_SUB   = 6'd29;
  localparam opc_t OP_SLL   = 6'd30;
  localparam opc_t OP_SLT   = 6'd31;
  localparam opc_t OP_SLTU  = 6'd32;
  localparam opc_t OP_XOR   = 6'd33;
  localparam opc_t OP_SRL   = 6'd34;
  localparam opc_t OP_SRA   = 6'd35;
  localparam opc_t OP_OR    = 6'd36;
  localparam opc_t OP_AND   = 6'd37;

  typedef enum logic [2:0] {
    SRC_REG,
    SRC_IMM,
    SRC_PC,
    SRC_FOUR,
    SRC_ZERO
  } src_t;

  typedef struct packed {
    logic mem;
    logic store;
    logic branch;
    src_t s1;
    src_t s2;
  } op_class_t;

  function automatic logic is_load(opc_t op);
    return op inside {[OP_LB:OP_LHU]};
  endfunction

  function automatic logic is_store(opc_t op);
    return op inside {[OP_SB:OP_SW]};
  endfunction

  function automatic logic is_branch(opc_t op);
    return op inside {[OP_BEQ:OP_BGEU]};
  endfunction

  function automatic logic is_alu_imm(opc_t op);
    return op inside {[OP_ADDI:OP_SRAI]};
  endfunction

  function automatic op_class_t classify(opc_t op);
    op_class_t c;
    c.mem    = is_load(op) || is_store(op);
    c.store  = is_store(op);
    c.branch = is_branch(op);
    c.s1     = SRC_REG;
    c.s2     = SRC_REG;
    unique case (1'b1)
      is_load(op), is_alu_imm(op), op == OP_JALR:
        c.s2 = SRC_IMM;
      op == OP_JAL: begin
        c.s1 = SRC_PC;
        c.s2 = SRC_FOUR;
      end
      op == OP_AUIPC: begin
        c.s1 = SRC_PC;
        c.s2 = SRC_IMM;
      end
      op == OP_LUI: begin
        c.s1 = SRC_ZERO;
        c.s2 = SRC_IMM;
      end
      default: ;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/issue_queue_fifo.sv
// In-order instruction queue: storage, wrapping pointers and occupancy.
// Push/pop arrive already qualified by the issue logic.
module issue_queue_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic         flush,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] wdata,
  output logic [W-1:0] rdata,
  output logic         full,
  output logic         empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] count;

  assign rdata = mem[rd_ptr];
  assign full  = count == CW'(DEPTH);
  assign empty = count == '0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (en) begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      unique case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Payload only; occupancy decides whether a slot is meaningful.
  always_ff @(posedge clk) begin
    if (en && !flush && push) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/issue_queue.sv
// Buffered issue stage: queues decoded instructions, resolves operands
// against regfile/CDB/last dispatch and dispatches in order to ROB+RS/LSB.
module issue_queue
  import issue_queue_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int XLEN  = 32,
  parameter int OP_W  = 6,
  parameter int TAG_W = 4
) (
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic             rdy_in,
  input  logic             clear,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [OP_W-1:0]  in_op,
  input  logic [4:0]       in_rd,
  input  logic [4:0]       in_rs1,
  input  logic [4:0]       in_rs2,
  input  logic [XLEN-1:0]  in_imm,
  input  logic [XLEN-1:0]  in_pc,
  output logic [4:0]       rf_rs1,
  output logic [4:0]       rf_rs2,
  input  logic [TAG_W-1:0] rf_q1,
  input  logic [TAG_W-1:0] rf_q2,
  input  logic [XLEN-1:0]  rf_v1,
  input  logic [XLEN-1:0]  rf_v2,
  input  logic             rob_full,
  input  logic             rs_full,
  input  logic             lsb_full,
  input  logic [TAG_W-1:0] rob_tag,
  input  logic             cdb_valid,
  input  logic [TAG_W-1:0] cdb_tag,
  input  logic [XLEN-1:0]  cdb_data,
  output logic             rob_we,
  output logic             rs_we,
  output logic             lsb_we,
  output logic             rf_we,
  output logic [OP_W-1:0]  d_op,
  output logic [XLEN-1:0]  d_pc,
  output logic [XLEN-1:0]  d_imm,
  output logic [4:0]       d_rd,
  output logic [TAG_W-1:0] d_q1,
  output logic [XLEN-1:0]  d_v1,
  output logic [TAG_W-1:0] d_q2,
  output logic [XLEN-1:0]  d_v2,
  output logic [TAG_W-1:0] d_tag
);

  localparam int EW = OP_W + 15 + 2 * XLEN;
  localparam logic [TAG_W-1:0] TAG_READY = '1;

  typedef struct packed {
    logic [TAG_W-1:0] q;
    logic [XLEN-1:0]  v;
  } opnd_t;

  logic [EW-1:0]   wdata;
  logic [EW-1:0]   rdata;
  logic            full;
  logic            empty;
  logic            push;
  logic            go;
  logic            wr_rd;
  logic            byp_valid;
  logic [OP_W-1:0] h_op;
  logic [4:0]      h_rd;
  logic [4:0]      h_rs1;
  logic [4:0]      h_rs2;
  logic [XLEN-1:0] h_imm;
  logic [XLEN-1:0] h_pc;
  op_class_t       cls;
  opnd_t           o1;
  opnd_t           o2;

  assign in_ready = !full;
  assign push     = in_valid && !full && rdy_in && !clear;
  assign wdata    = {in_op, in_rd, in_rs1, in_rs2, in_imm, in_pc};
  assign {h_op, h_rd, h_rs1, h_rs2, h_imm, h_pc} = rdata;
  assign rf_rs1   = h_rs1;
  assign rf_rs2   = h_rs2;

  issue_queue_fifo #(
    .DEPTH (DEPTH),
    .W     (EW)
  ) u_fifo (
    .clk   (clk_in),
    .rst   (rst_in),
    .en    (rdy_in),
    .flush (clear),
    .push  (push),
    .pop   (go),
    .wdata (wdata),
    .rdata (rdata),
    .full  (full),
    .empty (empty)
  );

  // Last dispatch's rename beats the regfile, which has not seen it yet.
  function automatic opnd_t resolve(
    input logic [4:0]       rs,
    input logic [TAG_W-1:0] fq,
    input logic [XLEN-1:0]  fv
  );
    opnd_t r;
    if (rs == 5'd0) begin
      r.q = TAG_READY;
      r.v = '0;
    end else begin
      if (byp_valid && d_rd == rs) begin
        r.q = d_tag;
        r.v = '0;
      end else begin
        r.q = fq;
        r.v = (fq == TAG_READY) ? fv : '0;
      end
      if (r.q != TAG_READY && cdb_valid && cdb_tag == r.q) begin
        r.q = TAG_READY;
        r.v = cdb_data;
      end
    end
    return r;
  endfunction

  function automatic opnd_t pick(
    input src_t             s,
    input logic [4:0]       rs,
    input logic [TAG_W-1:0] fq,
    input logic [XLEN-1:0]  fv
  );
    opnd_t r;
    r.q = TAG_READY;
    r.v = '0;
    unique case (s)
      SRC_REG:  r = resolve(rs, fq, fv);
      SRC_IMM:  r.v = h_imm;
      SRC_PC:   r.v = h_pc;
      SRC_FOUR: r.v = XLEN'(4);
      default:  r.v = '0;
    endcase
    return r;
  endfunction

  always_comb begin
    cls   = classify(OPC_W'(h_op));
    wr_rd = !(cls.store || cls.branch) && h_rd != 5'd0;
    go    = !empty && rdy_in && !clear && !rob_full
            && !(cls.mem ? lsb_full : rs_full);
    o1    = pick(cls.s1, h_rs1, rf_q1, rf_v1);
    o2    = pick(cls.s2, h_rs2, rf_q2, rf_v2);
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      rob_we    <= 1'b0;
      rs_we     <= 1'b0;
      lsb_we    <= 1'b0;
      rf_we     <= 1'b0;
      byp_valid <= 1'b0;
      d_op      <= '0;
      d_pc      <= '0;
      d_imm     <= '0;
      d_rd      <= '0;
      d_q1      <= '0;
      d_v1      <= '0;
      d_q2      <= '0;
      d_v2      <= '0;
      d_tag     <= '0;
    end else if (clear) begin
      rob_we    <= 1'b0;
      rs_we     <= 1'b0;
      lsb_we    <= 1'b0;
      rf_we     <= 1'b0;
      byp_valid <= 1'b0;
    end else if (!rdy_in) begin
      rob_we    <= 1'b0;
      rs_we     <= 1'b0;
      lsb_we    <= 1'b0;
      rf_we     <= 1'b0;
    end else begin
      rob_we    <= go;
      rs_we     <= go && !cls.mem;
      lsb_we    <= go && cls.mem;
      rf_we     <= go && wr_rd;
      byp_valid <= go && wr_rd;
      if (go) begin
        d_op  <= h_op;
        d_pc  <= h_pc;
        d_imm <= h_imm;
        d_rd  <= h_rd;
        d_q1  <= o1.q;
        d_v1  <= o1.v;
        d_q2  <= o2.q;
        d_v2  <= o2.v;
        d_tag <= rob_tag;
      end
    end
  end

endmodule

// File: tb/tb_issue_queue.sv
// Directed bench for issue_queue: vector table plus multi-cycle sequences.
module tb_issue_queue;
  import issue_queue_pkg::*;

  localparam logic [3:0] R = 4'hF;

  logic        clk_in = 1'b0;
  logic        rst_in;
  logic        rdy_in;
  logic        clear;
  logic        in_valid;
  logic        in_ready;
  logic [5:0]  in_op;
  logic [4:0]  in_rd;
  logic [4:0]  in_rs1;
  logic [4:0]  in_rs2;
  logic [31:0] in_imm;
  logic [31:0] in_pc;
  logic [4:0]  rf_rs1;
  logic [4:0]  rf_rs2;
  logic [3:0]  rf_q1;
  logic [3:0]  rf_q2;
  logic [31:0] rf_v1;
  logic [31:0] rf_v2;
  logic        rob_full;
  logic        rs_full;
  logic        lsb_full;
  logic [3:0]  rob_tag;
  logic        cdb_valid;
  logic [3:0]  cdb_tag;
  logic [31:0] cdb_data;
  logic        rob_we;
  logic        rs_we;
  logic        lsb_we;
  logic        rf_we;
  logic [5:0]  d_op;
  logic [31:0] d_pc;
  logic [31:0] d_imm;
  logic [4:0]  d_rd;
  logic [3:0]  d_q1;
  logic [31:0] d_v1;
  logic [3:0]  d_q2;
  logic [31:0] d_v2;
  logic [3:0]  d_tag;

  int errors = 0;
  int checks = 0;

  issue_queue dut (
    .clk_in   (clk_in),
    .rst_in   (rst_in),
    .rdy_in   (rdy_in),
    .clear    (clear),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_op    (in_op),
    .in_rd    (in_rd),
    .in_rs1   (in_rs1),
    .in_rs2   (in_rs2),
    .in_imm   (in_imm),
    .in_pc    (in_pc),
    .rf_rs1   (rf_rs1),
    .rf_rs2   (rf_rs2),
    .rf_q1    (rf_q1),
    .rf_q2    (rf_q2),
    .rf_v1    (rf_v1),
    .rf_v2    (rf_v2),
    .rob_full (rob_full),
    .rs_full  (rs_full),
    .lsb_full (lsb_full),
    .rob_tag  (rob_tag),
    .cdb_valid(cdb_valid),
    .cdb_tag  (cdb_tag),
    .cdb_data (cdb_data),
    .rob_we   (rob_we),
    .rs_we    (rs_we),
    .lsb_we   (lsb_we),
    .rf_we    (rf_we),
    .d_op     (d_op),
    .d_pc     (d_pc),
    .d_imm    (d_imm),
    .d_rd     (d_rd),
    .d_q1     (d_q1),
    .d_v1     (d_v1),
    .d_q2     (d_q2),
    .d_v2     (d_v2),
    .d_tag    (d_tag)
  );

  always #5 clk_in = ~clk_in;

  typedef struct {
    logic [5:0]  op;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [31:0] imm;
    logic [31:0] pc;
    logic [3:0]  q1;
    logic [31:0] v1;
    logic [3:0]  q2;
    logic [31:0] v2;
    logic        cv;
    logic [3:0]  ct;
    logic [31:0] cd;
    logic [3:0]  tag;
    logic        e_rs;
    logic        e_lsb;
    logic        e_rf;
    logic [3:0]  e_q1;
    logic [31:0] e_v1;
    logic [3:0]  e_q2;
    logic [31:0] e_v2;
  } vec_t;

  vec_t vecs [12];

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_in);
    #1;
  endtask

  task automatic set_in(input logic [5:0] op, input logic [4:0] rd,
                        input logic [4:0] rs1, input logic [4:0] rs2,
                        input logic [31:0] imm, input logic [31:0] pc);
    in_op  = op;
    in_rd  = rd;
    in_rs1 = rs1;
    in_rs2 = rs2;
    in_imm = imm;
    in_pc  = pc;
  endtask

  task automatic push(input logic [5:0] op, input logic [4:0] rd,
                      input logic [4:0] rs1, input logic [4:0] rs2,
                      input logic [31:0] imm);
    set_in(op, rd, rs1, rs2, imm, 32'h400);
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
  endtask

  task automatic chk_we(input string name, input logic rob,
                        input logic rs, input logic lsb, input logic rf);
    chk({name, ".rob_we"}, 64'(rob_we), 64'(rob));
    chk({name, ".rs_we"},  64'(rs_we),  64'(rs));
    chk({name, ".lsb_we"}, 64'(lsb_we), 64'(lsb));
    chk({name, ".rf_we"},  64'(rf_we),  64'(rf));
  endtask

  initial begin
    rst_in = 1'b1; rdy_in = 1'b1; clear = 1'b0; in_valid = 1'b0;
    set_in(OP_NOP, 0, 0, 0, 0, 0);
    rf_q1 = R; rf_q2 = R; rf_v1 = 0; rf_v2 = 0;
    rob_full = 0; rs_full = 0; lsb_full = 0; rob_tag = 0;
    cdb_valid = 0; cdb_tag = 0; cdb_data = 0;

    vecs[0]  = '{OP_ADDI, 1, 0, 0, 5, 32'h100, R, 0, R, 0, 0, 0, 0, 3,
                 1, 0, 1, R, 0, R, 5};
    vecs[1]  = '{OP_ADD, 3, 1, 2, 0, 32'h104, R, 11, R, 22, 0, 0, 0, 4,
                 1, 0, 1, R, 11, R, 22};
    vecs[2]  = '{OP_ADD, 3, 1, 2, 0, 32'h108, 5, 0, 6, 0, 1, 6, 77, 7,
                 1, 0, 1, 5, 0, R, 77};
    vecs[3]  = '{OP_BEQ, 9, 1, 2, 16, 32'h10C, R, 1, 2, 0, 0, 0, 0, 8,
                 1, 0, 0, R, 1, 2, 0};
    vecs[4]  = '{OP_LW, 5, 1, 0, 4, 32'h110, R, 32'h1000, R, 0, 0, 0, 0, 9,
                 0, 1, 1, R, 32'h1000, R, 4};
    vecs[5]  = '{OP_SW, 0, 2, 1, 8, 32'h114, R, 32'h2000, R, 32'hAB,
                 0, 0, 0, 10, 0, 1, 0, R, 32'h2000, R, 32'hAB};
    vecs[6]  = '{OP_JAL, 1, 0, 0, 32'h20, 32'h200, 3, 0, 3, 0, 0, 0, 0, 11,
                 1, 0, 1, R, 32'h200, R, 4};
    vecs[7]  = '{OP_LUI, 4, 0, 0, 32'h12345000, 32'h204, R, 0, R, 0,
                 0, 0, 0, 12, 1, 0, 1, R, 0, R, 32'h12345000};
    vecs[8]  = '{OP_AUIPC, 4, 0, 0, 32'h1000, 32'h300, R, 0, R, 0,
                 0, 0, 0, 13, 1, 0, 1, R, 32'h300, R, 32'h1000};
    vecs[9]  = '{OP_JALR, 1, 2, 0, 12, 32'h304, 2, 0, R, 0, 1, 2, 32'h55, 14,
                 1, 0, 1, R, 32'h55, R, 12};
    vecs[10] = '{OP_ADD, 0, 1, 2, 0, 32'h308, R, 3, R, 4, 0, 0, 0, 1,
                 1, 0, 0, R, 3, R, 4};
    vecs[11] = '{OP_ADD, 7, 0, 0, 0, 32'h30C, 5, 9, 6, 9, 0, 0, 0, 2,
                 1, 0, 1, R, 0, R, 0};

    step();
    step();
    chk_we("reset", 0, 0, 0, 0);
    chk("reset.in_ready", 64'(in_ready), 1);
    chk("reset.d_q1", 64'(d_q1), 0);
    chk("reset.d_imm", 64'(d_imm), 0);
    chk("reset.d_tag", 64'(d_tag), 0);
    rst_in = 1'b0;
    step();

    for (int i = 0; i < 12; i++) begin
      set_in(vecs[i].op, vecs[i].rd, vecs[i].rs1, vecs[i].rs2,
             vecs[i].imm, vecs[i].pc);
      rf_q1 = vecs[i].q1; rf_v1 = vecs[i].v1;
      rf_q2 = vecs[i].q2; rf_v2 = vecs[i].v2;
      rob_tag = vecs[i].tag;
      in_valid = 1'b1;
      step();
      in_valid = 1'b0;
      chk($sformatf("v%0d.no_strobe", i), 64'(rob_we), 0);
      chk($sformatf("v%0d.rf_rs1", i), 64'(rf_rs1), 64'(vecs[i].rs1));
      cdb_valid = vecs[i].cv; cdb_tag = vecs[i].ct; cdb_data = vecs[i].cd;
      step();
      cdb_valid = 1'b0;
      chk_we($sformatf("v%0d", i), 1, vecs[i].e_rs, vecs[i].e_lsb,
             vecs[i].e_rf);
      chk($sformatf("v%0d.d_q1", i), 64'(d_q1), 64'(vecs[i].e_q1));
      chk($sformatf("v%0d.d_v1", i), 64'(d_v1), 64'(vecs[i].e_v1));
      chk($sformatf("v%0d.d_q2", i), 64'(d_q2), 64'(vecs[i].e_q2));
      chk($sformatf("v%0d.d_v2", i), 64'(d_v2), 64'(vecs[i].e_v2));
      chk($sformatf("v%0d.d_imm", i), 64'(d_imm), 64'(vecs[i].imm));
      chk($sformatf("v%0d.d_pc", i), 64'(d_pc), 64'(vecs[i].pc));
      chk($sformatf("v%0d.d_rd", i), 64'(d_rd), 64'(vecs[i].rd));
      chk($sformatf("v%0d.d_op", i), 64'(d_op), 64'(vecs[i].op));
      chk($sformatf("v%0d.d_tag", i), 64'(d_tag), 64'(vecs[i].tag));
    end
    rf_q1 = R; rf_q2 = R; rf_v1 = 100; rf_v2 = 100;
    step();

    // back-to-back dependent pair, without and with CDB at dispatch
    for (int k = 0; k < 2; k++) begin
      set_in(OP_ADDI, 1, 0, 0, 5, 32'h500);
      in_valid = 1'b1; rob_tag = 3;
      step();
      set_in(OP_ADD, 2, 1, 1, 0, 32'h504);
      step();
      in_valid = 1'b0; rob_tag = 4;
      chk_we($sformatf("byp%0d.addi", k), 1, 1, 0, 1);
      chk($sformatf("byp%0d.addi_tag", k), 64'(d_tag), 3);
      if (k == 1) begin
        cdb_valid = 1'b1; cdb_tag = 3; cdb_data = 9;
      end
      step();
      cdb_valid = 1'b0;
      chk_we($sformatf("byp%0d.add", k), 1, 1, 0, 1);
      chk($sformatf("byp%0d.d_q1", k), 64'(d_q1), k ? 64'(R) : 3);
      chk($sformatf("byp%0d.d_v1", k), 64'(d_v1), k ? 9 : 0);
      chk($sformatf("byp%0d.d_q2", k), 64'(d_q2), k ? 64'(R) : 3);
      chk($sformatf("byp%0d.d_v2", k), 64'(d_v2), k ? 9 : 0);
      chk($sformatf("byp%0d.d_tag", k), 64'(d_tag), 4);
      step();
      step();
    end

    // store held by a full LSB
    lsb_full = 1'b1;
    push(OP_SW, 0, 2, 1, 8);
    for (int c = 0; c < 3; c++) begin
      step();
      chk($sformatf("lsbfull%0d.lsb_we", c), 64'(lsb_we), 0);
      chk($sformatf("lsbfull%0d.rob_we", c), 64'(rob_we), 0);
    end
    lsb_full = 1'b0;
    step();
    chk_we("lsbrel", 1, 0, 1, 0);
    chk("lsbrel.d_imm", 64'(d_imm), 8);
    step();
    chk("lsbrel.once", 64'(lsb_we), 0);

    // fill past capacity behind a full ROB, then drain in order
    rob_full = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("fill%0d.in_ready", i), 64'(in_ready), 1);
      push(OP_ADDI, 5'(i + 1), 0, 0, 32'(i));
    end
    chk("fill.full_ready", 64'(in_ready), 0);
    set_in(OP_ADDI, 5, 0, 0, 4, 32'h400);
    in_valid = 1'b1;
    step();
    chk("fill.held", 64'(rob_we), 0);
    chk("fill.still_full", 64'(in_ready), 0);
    rob_full = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      if (i == 1) in_valid = 1'b0;
      chk($sformatf("drain%0d.rob_we", i), 64'(rob_we), 1);
      chk($sformatf("drain%0d.d_imm", i), 64'(d_imm), 64'(i));
    end
    step();
    chk("drain.empty", 64'(rob_we), 0);

    // flush with entries queued and a dispatch ready
    rob_full = 1'b1;
    for (int i = 0; i < 3; i++) push(OP_ADDI, 6, 0, 0, 32'(10 + i));
    rob_full = 1'b0;
    clear = 1'b1;
    set_in(OP_ADDI, 6, 0, 0, 99, 32'h400);
    in_valid = 1'b1;
    step();
    clear = 1'b0;
    in_valid = 1'b0;
    chk("clear.rob_we", 64'(rob_we), 0);
    chk("clear.in_ready", 64'(in_ready), 1);
    step();
    chk("clear.empty", 64'(rob_we), 0);
    push(OP_ADDI, 6, 0, 0, 20);
    step();
    chk("clear.after", 64'(rob_we), 1);
    chk("clear.after_imm", 64'(d_imm), 20);

    // freeze mid-stream
    rob_full = 1'b1;
    for (int i = 0; i < 3; i++) push(OP_ADDI, 7, 0, 0, 32'(30 + i));
    rob_full = 1'b0;
    step();
    chk("frz.a", 64'(d_imm), 30);
    rdy_in = 1'b0;
    for (int c = 0; c < 2; c++) begin
      step();
      chk($sformatf("frz%0d.rob_we", c), 64'(rob_we), 0);
      chk($sformatf("frz%0d.hold", c), 64'(d_imm), 30);
    end
    rdy_in = 1'b1;
    step();
    chk("frz.b_we", 64'(rob_we), 1);
    chk("frz.b", 64'(d_imm), 31);
    step();
    chk("frz.c", 64'(d_imm), 32);

    // async reset while a strobe is high
    push(OP_ADDI, 8, 0, 0, 40);
    step();
    chk("ares.pre", 64'(rob_we), 1);
    #2 rst_in = 1'b1;
    #1;
    chk_we("ares", 0, 0, 0, 0);
    chk("ares.d_imm", 64'(d_imm), 0);
    step();
    rst_in = 1'b0;
    step();
    chk("ares.ready", 64'(in_ready), 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
